// File: rtl/tpu_ram_pkg.sv
// Shared definitions for the TPU-side RAM blocks.
//   RDW_OLD / RDW_NEW : cross-port read-during-write selection values
//   clr_state_t       : post-reset clear sequencer states
//   merge()           : byte-lane merge of a new word over an old word.
//                       It works on MERGE_W bits; callers size-cast in and
//                       out, so data widths up to MERGE_W are supported.
package tpu_ram_pkg;

    localparam int RDW_OLD  = 0;
    localparam int RDW_NEW  = 1;

    localparam int MERGE_W  = 512;
    localparam int MERGE_BE = MERGE_W / 8;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clr_state_t;

    function automatic logic [MERGE_W-1:0] merge(
        input logic [MERGE_W-1:0]  old_w,
        input logic [MERGE_W-1:0]  new_w,
        input logic [MERGE_BE-1:0] be
    );
        logic [MERGE_W-1:0] r;
        r = old_w;
        for (int i = 0; i < MERGE_BE; i++)
            if (be[i]) r[8*i +: 8] = new_w[8*i +: 8];
        return r;
    endfunction

endpackage

// File: rtl/dpram_be_core.sv
// Bare byte-enabled dual-port array with registered, read-old-data reads.
// No reset: contents are only defined by writes (the top clears it).
//   clk              : clock
//   addr_a/addr_b    : word address (caller guarantees < NUM_WORDS on use)
//   we_a/we_b        : per-byte write enables
//   wdata_a/wdata_b  : write data
//   rd_a/rd_b        : read strobe; q_x holds when low
//   q_a/q_b          : read data, one cycle after rd_x
// When both ports write the same byte, port A's value lands.
module dpram_be_core #(
    parameter int AWIDTH    = 10,
    parameter int NUM_WORDS = 1024,
    parameter int DWIDTH    = 32
) (
    input  logic                clk,
    input  logic [AWIDTH-1:0]   addr_a,
    input  logic [AWIDTH-1:0]   addr_b,
    input  logic [DWIDTH/8-1:0] we_a,
    input  logic [DWIDTH/8-1:0] we_b,
    input  logic [DWIDTH-1:0]   wdata_a,
    input  logic [DWIDTH-1:0]   wdata_b,
    input  logic                rd_a,
    input  logic                rd_b,
    output logic [DWIDTH-1:0]   q_a,
    output logic [DWIDTH-1:0]   q_b
);

`ifdef SIMULATION_MEMORY
    localparam bit USE_VENDOR = 1'b0;
`elsif VENDOR_DUAL_PORT_RAM
    localparam bit USE_VENDOR = 1'b1;
`else
    localparam bit USE_VENDOR = 1'b0;
`endif

    if (!USE_VENDOR) begin : g_beh
        localparam int NB = DWIDTH / 8;
        localparam int IW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

        logic [DWIDTH-1:0] mem [NUM_WORDS];
        logic [IW-1:0]     ia, ib;

        assign ia = addr_a[IW-1:0];
        assign ib = addr_b[IW-1:0];

        // Reads see the pre-write contents (NBA ordering). B's bytes are
        // scheduled before A's so A wins a shared byte.
        always_ff @(posedge clk) begin
            if (rd_a) q_a <= mem[ia];
            if (rd_b) q_b <= mem[ib];
            for (int i = 0; i < NB; i++) begin
                if (we_b[i]) mem[ib][8*i +: 8] <= wdata_b[8*i +: 8];
                if (we_a[i]) mem[ia][8*i +: 8] <= wdata_a[8*i +: 8];
            end
        end
    end

`ifndef SIMULATION_MEMORY
`ifdef VENDOR_DUAL_PORT_RAM
    // The vendor primitive has native byte enables, so no read-modify-write
    // is needed. It must be configured read-old-data with port A priority.
    dual_port_ram #(
        .AWIDTH    (AWIDTH),
        .NUM_WORDS (NUM_WORDS),
        .DWIDTH    (DWIDTH)
    ) u_ram (
        .clk       (clk),
        .address_a (addr_a),
        .address_b (addr_b),
        .data_a    (wdata_a),
        .data_b    (wdata_b),
        .byteena_a (we_a),
        .byteena_b (we_b),
        .wren_a    (|we_a),
        .wren_b    (|we_b),
        .rden_a    (rd_a),
        .rden_b    (rd_b),
        .q_a       (q_a),
        .q_b       (q_b)
    );
`endif
`endif

endmodule

// File: rtl/dpram_be.sv
// Dual-port RAM with byte enables, read valid strobes, selectable
// read-during-write behaviour, optional output register, A-over-B write
// arbitration and an optional post-reset clear sequencer.
//   clk, reset             : clock, synchronous active-high reset
//   busy                   : clear running; port requests are dropped
//   address_x, wren_x,
//   rden_x, byteen_x,
//   data_x                 : per-port request
//   out_x, valid_x         : read data (held between reads) and new-data pulse
//   collision              : both ports wrote overlapping bytes of one word
module dpram_be
    import tpu_ram_pkg::*;
#(
    parameter int AWIDTH         = 10,
    parameter int NUM_WORDS      = 1024,
    parameter int DWIDTH         = 32,
    parameter int OUT_REG        = 0,
    parameter int RDW_MODE       = RDW_OLD,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                clk,
    input  logic                reset,
    output logic                busy,
    input  logic [AWIDTH-1:0]   address_a,
    input  logic [AWIDTH-1:0]   address_b,
    input  logic                wren_a,
    input  logic                wren_b,
    input  logic                rden_a,
    input  logic                rden_b,
    input  logic [DWIDTH/8-1:0] byteen_a,
    input  logic [DWIDTH/8-1:0] byteen_b,
    input  logic [DWIDTH-1:0]   data_a,
    input  logic [DWIDTH-1:0]   data_b,
    output logic [DWIDTH-1:0]   out_a,
    output logic [DWIDTH-1:0]   out_b,
    output logic                valid_a,
    output logic                valid_b,
    output logic                collision
);

    localparam int              NB    = DWIDTH / 8;
    localparam logic [AWIDTH:0] LIMIT = (AWIDTH+1)'(NUM_WORDS);
    localparam logic [AWIDTH-1:0] LAST = AWIDTH'(NUM_WORDS - 1);

    // ---------------- clear sequencer ----------------
    clr_state_t        state;
    logic [AWIDTH-1:0] clr_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;
            clr_cnt <= '0;
        end else if (state == CLEAR) begin
            clr_cnt <= clr_cnt + 1'b1;
            if (clr_cnt == LAST) state <= IDLE;
        end
    end

    assign busy = (state == CLEAR);

    // ---------------- request masking ----------------
    logic [1:0][AWIDTH-1:0] addr;
    logic [1:0][DWIDTH-1:0] wdata, q, dout;
    logic [1:0][NB-1:0]     be, wbe;
    logic [1:0]             wren, rden, in_rng, wr, rd, vld;
    logic                   accept, clr_we, col_now, col1, col2;

    assign addr   = {address_b, address_a};
    assign wdata  = {data_b, data_a};
    assign be     = {byteen_b, byteen_a};
    assign wren   = {wren_b, wren_a};
    assign rden   = {rden_b, rden_a};
    assign accept = (state == IDLE) && !reset;
    assign clr_we = busy && !reset;

    for (genvar p = 0; p < 2; p++) begin : g_port
        localparam int O = 1 - p;

        logic              v1, v2, oob1;
        logic [NB-1:0]     fwd_be;
        logic [DWIDTH-1:0] fwd_d, merged, rd1, out_r;

        assign in_rng[p] = ({1'b0, addr[p]} < LIMIT);
        assign wr[p]     = accept && wren[p];
        // A same-port write takes the cycle; the read is dropped.
        assign rd[p]     = accept && rden[p] && !wren[p];
        assign wbe[p]    = (wr[p] && in_rng[p]) ? be[p] : '0;

        // Capture what the other port wrote to our address this cycle so
        // the registered old word can be patched one cycle later. A reading
        // port never writes, so the other port's bytes are the full merge.
        always_ff @(posedge clk) begin
            fwd_be <= (addr[p] == addr[O]) ? wbe[O] : '0;
            fwd_d  <= wdata[O];
            oob1   <= !in_rng[p];
        end

        assign merged = DWIDTH'(merge(MERGE_W'(q[p]), MERGE_W'(fwd_d),
                                      MERGE_BE'(fwd_be)));
        assign rd1    = oob1 ? '0 : ((RDW_MODE == RDW_NEW) ? merged : q[p]);

        // out_r doubles as the hold register (OUT_REG=0) and the output
        // stage (OUT_REG=1).
        always_ff @(posedge clk) begin
            if (reset) begin
                v1    <= 1'b0;
                v2    <= 1'b0;
                out_r <= '0;
            end else begin
                v1 <= rd[p];
                v2 <= v1;
                if (v1) out_r <= rd1;
            end
        end

        assign vld[p]  = (OUT_REG != 0) ? v2 : v1;
        assign dout[p] = (OUT_REG != 0) ? out_r : (v1 ? rd1 : out_r);
    end

    assign out_a   = dout[0];
    assign out_b   = dout[1];
    assign valid_a = vld[0];
    assign valid_b = vld[1];

    // ---------------- collision ----------------
    assign col_now = wr[0] && wr[1] && in_rng[0] && in_rng[1] &&
                     (address_a == address_b) && (|(byteen_a & byteen_b));

    always_ff @(posedge clk) begin
        if (reset) begin
            col1 <= 1'b0;
            col2 <= 1'b0;
        end else begin
            col1 <= col_now;
            col2 <= col1;
        end
    end

    assign collision = (OUT_REG != 0) ? col2 : col1;

    // ---------------- storage ----------------
    dpram_be_core #(
        .AWIDTH    (AWIDTH),
        .NUM_WORDS (NUM_WORDS),
        .DWIDTH    (DWIDTH)
    ) u_core (
        .clk     (clk),
        .addr_a  (clr_we ? clr_cnt : address_a),
        .addr_b  (address_b),
        .we_a    (clr_we ? {NB{1'b1}} : wbe[0]),
        .we_b    (wbe[1]),
        .wdata_a (clr_we ? '0 : data_a),
        .wdata_b (data_b),
        .rd_a    (rd[0] && in_rng[0]),
        .rd_b    (rd[1] && in_rng[1]),
        .q_a     (q[0]),
        .q_b     (q[1])
    );

endmodule

// File: tb/tb_dpram_be.sv
// Bench for dpram_be: two instances share stimulus.
//   dut0: OUT_REG=0, RDW_MODE=0   dut1: OUT_REG=1, RDW_MODE=1
// Expected reads/collisions are queued when issued; a monitor pops and
// compares (data and latency) whenever a DUT presents valid/collision.
module tb_dpram_be;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  address_a, address_b;
    logic        wren_a, wren_b, rden_a, rden_b;
    logic [3:0]  byteen_a, byteen_b;
    logic [31:0] data_a, data_b;
    logic        busy0, busy1, valid_a0, valid_b0, valid_a1, valid_b1;
    logic        collision0, collision1;
    logic [31:0] out_a0, out_b0, out_a1, out_b1;

    always #5 clk = ~clk;

    dpram_be #(.AWIDTH(5), .NUM_WORDS(16), .DWIDTH(32), .OUT_REG(0),
               .RDW_MODE(0), .CLEAR_ON_RESET(1)) dut0 (
        .clk(clk), .reset(reset), .busy(busy0),
        .address_a(address_a), .address_b(address_b),
        .wren_a(wren_a), .wren_b(wren_b), .rden_a(rden_a), .rden_b(rden_b),
        .byteen_a(byteen_a), .byteen_b(byteen_b),
        .data_a(data_a), .data_b(data_b),
        .out_a(out_a0), .out_b(out_b0), .valid_a(valid_a0), .valid_b(valid_b0),
        .collision(collision0));

    dpram_be #(.AWIDTH(5), .NUM_WORDS(16), .DWIDTH(32), .OUT_REG(1),
               .RDW_MODE(1), .CLEAR_ON_RESET(1)) dut1 (
        .clk(clk), .reset(reset), .busy(busy1),
        .address_a(address_a), .address_b(address_b),
        .wren_a(wren_a), .wren_b(wren_b), .rden_a(rden_a), .rden_b(rden_b),
        .byteen_a(byteen_a), .byteen_b(byteen_b),
        .data_a(data_a), .data_b(data_b),
        .out_a(out_a1), .out_b(out_b1), .valid_a(valid_a1), .valid_b(valid_b1),
        .collision(collision1));

    typedef struct { logic [31:0] data; int cyc; } exp_t;

    exp_t        sb  [4][$];   // 0:a0 1:b0 2:a1 3:b1
    int          csb [2][$];
    int          checks = 0, failures = 0, cyc = 0;
    logic [3:0]  mvld;
    logic [1:0]  mcol;
    logic [31:0] mdat [4];

    assign mvld    = {valid_b1, valid_a1, valid_b0, valid_a0};
    assign mcol    = {collision1, collision0};
    assign mdat[0] = out_a0;
    assign mdat[1] = out_b0;
    assign mdat[2] = out_a1;
    assign mdat[3] = out_b1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: latency is 1 cycle for dut0 and 2 for dut1.
    always @(negedge clk) begin
        exp_t e;
        int   c;
        for (int k = 0; k < 4; k++) begin
            if (mvld[k] === 1'b1) begin
                if (sb[k].size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_valid ch=%0d got=%h exp=none", k, mdat[k]);
                end else begin
                    e = sb[k].pop_front();
                    check($sformatf("data_ch%0d", k), mdat[k], e.data);
                    check($sformatf("lat_ch%0d", k), cyc - e.cyc, (k < 2) ? 1 : 2);
                end
            end
        end
        for (int d = 0; d < 2; d++) begin
            if (mcol[d] === 1'b1) begin
                if (csb[d].size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_collision dut=%0d got=1 exp=0", d);
                end else begin
                    c = csb[d].pop_front();
                    check($sformatf("col_lat%0d", d), cyc - c, d + 1);
                end
            end
        end
    end

    task automatic idle_in();
        wren_a = 0; rden_a = 0; address_a = 0; byteen_a = 0; data_a = 0;
        wren_b = 0; rden_b = 0; address_b = 0; byteen_b = 0; data_b = 0;
    endtask

    task automatic port_a(input logic wr, rd, input logic [4:0] ad,
                          input logic [3:0] be, input logic [31:0] d);
        wren_a = wr; rden_a = rd; address_a = ad; byteen_a = be; data_a = d;
    endtask

    task automatic port_b(input logic wr, rd, input logic [4:0] ad,
                          input logic [3:0] be, input logic [31:0] d);
        wren_b = wr; rden_b = rd; address_b = ad; byteen_b = be; data_b = d;
    endtask

    task automatic exp_a(input logic [31:0] d0, d1);
        sb[0].push_back('{d0, cyc});
        sb[2].push_back('{d1, cyc});
    endtask

    task automatic exp_b(input logic [31:0] d0, d1);
        sb[1].push_back('{d0, cyc});
        sb[3].push_back('{d1, cyc});
    endtask

    task automatic exp_col();
        csb[0].push_back(cyc);
        csb[1].push_back(cyc);
    endtask

    task automatic tick();
        @(negedge clk);
        idle_in();
    endtask

    // Counts negedges with busy high (bounded); optionally drives an
    // early write to address 3 at iteration wr_at.
    task automatic count_busy(input int wr_at, output int n0, output int n1);
        n0 = 0; n1 = 0;
        for (int i = 0; i < 100 && (busy0 || busy1); i++) begin
            n0 += int'(busy0);
            n1 += int'(busy1);
            if (i == wr_at) port_a(1, 0, 3, 4'hF, 32'h0000000F);
            else            idle_in();
            @(negedge clk);
        end
        idle_in();
    endtask

    initial begin
        int n0, n1;
        reset = 1;
        idle_in();
        repeat (3) @(negedge clk);
        check("rst_busy0", busy0, 1);
        check("rst_busy1", busy1, 1);
        check("rst_out_a0", out_a0, 0);
        check("rst_out_b1", out_b1, 0);
        check("rst_valid_a1", valid_a1, 0);
        check("rst_collision0", collision0, 0);

        reset = 0;
        count_busy(-1, n0, n1);
        check("busy_len0", n0, 16);
        check("busy_len1", n1, 16);

        // first accepted read after clear
        port_a(0, 1, 5, 0, 0); exp_a(0, 0); tick();

        // byte enables
        port_a(1, 0, 3, 4'hF, 32'hAABBCCDD); tick();
        port_a(1, 0, 3, 4'h5, 32'h11223344); tick();
        port_a(0, 1, 3, 0, 0); exp_a(32'hAA22CC44, 32'hAA22CC44); tick();

        // dual write, overlap on byte 1: A wins bytes 0,1; B keeps byte 2
        port_a(1, 0, 7, 4'h3, 32'h11111111);
        port_b(1, 0, 7, 4'h6, 32'h22222222); exp_col(); tick();
        port_b(0, 1, 7, 0, 0); exp_b(32'h00221111, 32'h00221111); tick();

        // dual write, disjoint bytes: no collision; then zero-enable writes
        port_a(1, 0, 8, 4'h1, 32'h000000AA);
        port_b(1, 0, 8, 4'h8, 32'hBB000000); tick();
        port_a(1, 0, 8, 4'h0, 32'hFFFFFFFF);
        port_b(1, 0, 8, 4'h0, 32'hFFFFFFFF); tick();
        port_a(0, 1, 8, 0, 0); exp_a(32'hBB0000AA, 32'hBB0000AA); tick();

        // cross-port read during write
        port_a(1, 0, 9, 4'hF, 32'h12345678); tick();
        port_a(1, 0, 9, 4'h2, 32'hAABBCCDD);
        port_b(0, 1, 9, 0, 0); exp_b(32'h12345678, 32'h1234CC78); tick();
        port_a(1, 0, 9, 4'hF, 32'h5); tick();
        port_a(1, 0, 9, 4'hF, 32'h6);
        port_b(0, 1, 9, 0, 0); exp_b(32'h5, 32'h6); tick();
        port_b(0, 1, 9, 0, 0); exp_b(32'h6, 32'h6); tick();

        // same-port write+read: write wins, no valid
        port_a(1, 1, 10, 4'hF, 32'h77); tick();
        port_a(0, 1, 10, 0, 0); exp_a(32'h77, 32'h77); tick();
        port_a(1, 1, 11, 4'hF, 32'h99); tick();
        repeat (2) @(negedge clk);
        check("hold_a0", out_a0, 32'h77);
        check("hold_a1", out_a1, 32'h77);

        // out of range: write ignored (no alias onto 3), read gives 0
        port_a(1, 0, 19, 4'hF, 32'hDEADBEEF); tick();
        port_a(0, 1, 20, 0, 0); exp_a(0, 0); tick();
        port_b(0, 1, 3, 0, 0); exp_b(32'hAA22CC44, 32'hAA22CC44); tick();

        // back-to-back writes then reads
        for (int i = 0; i < 8; i++) begin
            port_a(1, 0, 5'(i), 4'hF, 32'(i)); tick();
        end
        for (int i = 0; i < 8; i++) begin
            port_a(0, 1, 5'(i), 0, 0); exp_a(32'(i), 32'(i)); tick();
        end
        repeat (3) @(negedge clk);

        // reset mid-stream: dut1's last read is still in its output stage
        for (int i = 0; i < 4; i++) begin
            port_a(0, 1, 5'(i), 0, 0);
            if (i < 3) exp_a(32'(i), 32'(i));
            else       sb[0].push_back('{32'(i), cyc});
            tick();
        end
        reset = 1;
        @(negedge clk);
        check("midrst_out_a0", out_a0, 0);
        check("midrst_valid_a0", valid_a0, 0);
        check("midrst_out_a1", out_a1, 0);
        check("midrst_valid_a1", valid_a1, 0);

        // reset mid-clear at counter = 10, early write must be dropped
        reset = 0;
        repeat (10) @(negedge clk);
        reset = 1;
        @(negedge clk);
        reset = 0;
        count_busy(5, n0, n1);
        check("reclear_len0", n0, 16);
        check("reclear_len1", n1, 16);
        for (int i = 0; i < 8; i++) begin
            port_a(0, 1, 5'(i), 0, 0); exp_a(0, 0); tick();
        end
        port_b(0, 1, 9, 0, 0); exp_b(0, 0); tick();
        repeat (4) @(negedge clk);

        for (int k = 0; k < 4; k++) check($sformatf("drain_ch%0d", k), sb[k].size(), 0);
        for (int d = 0; d < 2; d++) check($sformatf("drain_col%0d", d), csb[d].size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        failures++;
        $display("FAIL watchdog got=timeout exp=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
